// File: rtl/tdm_demux_if.sv
// Link-side bundle for the TDM demultiplexer: multiplexed input word plus
// the per-lane outputs and frame status.
interface tdm_demux_if #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned W    = 8
);
  logic                in_valid;
  logic                in_sof;
  logic [W-1:0]        in_data;
  logic [N_CH*W-1:0]   out_data;
  logic [N_CH-1:0]     out_valid;
  logic                frame_done;
  logic                sync_err;
  logic                locked;

  // Driver of the multiplexed stream, consumer of the lanes.
  modport master (
    output in_valid, in_sof, in_data,
    input  out_data, out_valid, frame_done, sync_err, locked
  );

  // The demultiplexer itself.
  modport slave (
    input  in_valid, in_sof, in_data,
    output out_data, out_valid, frame_done, sync_err, locked
  );
endinterface

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: locks to the start-of-frame marker and steers
// each word of the stream to its own registered lane.
module tdm_demux #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned W    = 8
) (
  input logic        clk,
  input logic        rst_n,
  tdm_demux_if.slave bus
);

  localparam int unsigned ChW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [ChW-1:0] LastCh = ChW'(N_CH - 1);

  typedef enum logic {StHunt, StLock} state_e;

  state_e              state_q, state_d;
  logic [ChW-1:0]      ch_q, ch_d;
  logic [N_CH*W-1:0]   data_q, data_d;
  logic [N_CH-1:0]     valid_q, valid_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                wr_en;
  logic [ChW-1:0]      wr_idx;

  // Framing decisions and lane steering for the word presented this cycle.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    data_d  = data_q;
    valid_d = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = ch_q;

    if (bus.in_valid) begin
      unique case (state_q)
        StHunt: begin
          if (bus.in_sof) begin
            wr_en   = 1'b1;
            wr_idx  = '0;
            ch_d    = ChW'(1);
            state_d = StLock;
          end
        end
        StLock: begin
          if (bus.in_sof) begin
            // A marker mid-frame truncates the frame but still resynchronises.
            err_d  = (ch_q != '0);
            wr_en  = 1'b1;
            wr_idx = '0;
            ch_d   = ChW'(1);
          end else if (ch_q == '0) begin
            // Expected a marker: frame too long or marker lost.
            err_d   = 1'b1;
            ch_d    = '0;
            state_d = StHunt;
          end else begin
            wr_en  = 1'b1;
            wr_idx = ch_q;
            if (ch_q == LastCh) begin
              done_d = 1'b1;
              ch_d   = '0;
            end else begin
              ch_d = ch_q + ChW'(1);
            end
          end
        end
        default: begin
          state_d = StHunt;
          ch_d    = '0;
        end
      endcase
    end

    for (int k = 0; k < int'(N_CH); k++) begin
      if (wr_en && (wr_idx == ChW'(k))) begin
        data_d[k*W +: W] = bus.in_data;
        valid_d[k]       = 1'b1;
      end
    end
  end

  // State, lane and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StHunt;
      ch_q    <= '0;
      data_q  <= '0;
      valid_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.out_data   = data_q;
  assign bus.out_valid  = valid_q;
  assign bus.frame_done = done_q;
  assign bus.sync_err   = err_q;
  assign bus.locked     = (state_q == StLock);

endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux: a 4-channel and a 3-channel instance.
module tb_tdm_demux;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tdm_demux_if #(.N_CH(4), .W(8)) b4 ();
  tdm_demux_if #(.N_CH(3), .W(8)) b3 ();

  tdm_demux #(.N_CH(4), .W(8)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  tdm_demux #(.N_CH(3), .W(8)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  typedef struct {
    int          cyc;
    logic [3:0]  ov;
    logic [31:0] dat;
    logic        fd;
    logic        se;
    logic        lk;
  } exp_t;

  exp_t        q4[$];
  exp_t        q3[$];
  exp_t        e4, e3;
  logic [7:0]  m4[4];
  logic [7:0]  m3[3];
  int          errs = 0;
  int          checks = 0;
  int          cyc = 0;
  int          fd3 = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle on the selected link; push the expected output event.
  task automatic send(input int sel, input bit v, input bit sof, input logic [7:0] d,
                      input int lane, input bit fd, input bit se, input bit lk);
    exp_t e;
    @(posedge clk);
    #1;
    if (sel == 0) begin
      b4.in_valid = v; b4.in_sof = sof; b4.in_data = d; b3.in_valid = 1'b0;
    end else begin
      b3.in_valid = v; b3.in_sof = sof; b3.in_data = d; b4.in_valid = 1'b0;
    end
    if (v && (lane >= 0 || se)) begin
      e.cyc = cyc + 1;
      e.ov  = '0;
      e.fd  = fd;
      e.se  = se;
      e.lk  = lk;
      if (sel == 0) begin
        if (lane >= 0) begin m4[lane] = d; e.ov[lane] = 1'b1; end
        e.dat = {m4[3], m4[2], m4[1], m4[0]};
        q4.push_back(e);
      end else begin
        if (lane >= 0) begin m3[lane] = d; e.ov[lane] = 1'b1; end
        e.dat = {8'h00, m3[2], m3[1], m3[0]};
        q3.push_back(e);
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (q4.size() != 0 || q3.size() != 0); i++) @(posedge clk);
    chk("drain_pending", 32'(q4.size() + q3.size()), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data4"}, b4.out_data, 32'h0);
    chk({tag, "_valid4"}, 32'(b4.out_valid), 32'h0);
    chk({tag, "_done4"}, 32'(b4.frame_done), 32'h0);
    chk({tag, "_err4"}, 32'(b4.sync_err), 32'h0);
    chk({tag, "_locked4"}, 32'(b4.locked), 32'h0);
    chk({tag, "_data3"}, 32'(b3.out_data), 32'h0);
    chk({tag, "_locked3"}, 32'(b3.locked), 32'h0);
  endtask

  // Monitor for the 4-channel instance.
  always @(negedge clk) begin
    if (rst_n && (|b4.out_valid || b4.frame_done || b4.sync_err)) begin
      if (q4.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL n4_spurious: out_valid=%b done=%b err=%b, no event expected",
                 b4.out_valid, b4.frame_done, b4.sync_err);
      end else begin
        e4 = q4.pop_front();
        chk("n4_cycle", 32'(cyc), 32'(e4.cyc));
        chk("n4_out_valid", 32'(b4.out_valid), 32'(e4.ov));
        chk("n4_out_data", b4.out_data, e4.dat);
        chk("n4_frame_done", 32'(b4.frame_done), 32'(e4.fd));
        chk("n4_sync_err", 32'(b4.sync_err), 32'(e4.se));
        chk("n4_locked", 32'(b4.locked), 32'(e4.lk));
      end
    end
  end

  // Monitor for the 3-channel instance.
  always @(negedge clk) begin
    if (rst_n && (|b3.out_valid || b3.frame_done || b3.sync_err)) begin
      if (b3.frame_done) fd3++;
      if (q3.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL n3_spurious: out_valid=%b done=%b err=%b, no event expected",
                 b3.out_valid, b3.frame_done, b3.sync_err);
      end else begin
        e3 = q3.pop_front();
        chk("n3_cycle", 32'(cyc), 32'(e3.cyc));
        chk("n3_out_valid", 32'(b3.out_valid), 32'(e3.ov));
        chk("n3_out_data", 32'(b3.out_data), e3.dat);
        chk("n3_frame_done", 32'(b3.frame_done), 32'(e3.fd));
        chk("n3_sync_err", 32'(b3.sync_err), 32'(e3.se));
        chk("n3_locked", 32'(b3.locked), 32'(e3.lk));
      end
    end
  end

  initial begin
    b4.in_valid = 1'b0; b4.in_sof = 1'b0; b4.in_data = '0;
    b3.in_valid = 1'b0; b3.in_sof = 1'b0; b3.in_data = '0;
    foreach (m4[i]) m4[i] = '0;
    foreach (m3[i]) m3[i] = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_zero("por");
    #19 rst_n = 1'b1;

    // Hunt: words without a marker are dropped.
    send(0, 1, 0, 8'hAA, -1, 0, 0, 0);
    send(0, 1, 0, 8'hBB, -1, 0, 0, 0);
    send(0, 0, 0, 8'h00, -1, 0, 0, 0);
    @(negedge clk);
    chk("hunt_data4", b4.out_data, 32'h0);
    chk("hunt_locked4", 32'(b4.locked), 32'h0);
    send(0, 1, 1, 8'h01, 0, 0, 0, 1);
    send(0, 0, 0, 8'h00, -1, 0, 0, 0);
    drain();

    // Asynchronous reset mid-stream while a word is being presented.
    send(0, 1, 0, 8'h02, -1, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1 chk_zero("midrst");
    q4.delete();
    foreach (m4[i]) m4[i] = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Clean frames; the held 0x02 word is discarded while hunting.
    send(0, 1, 1, 8'h11, 0, 0, 0, 1);
    send(0, 1, 0, 8'h22, 1, 0, 0, 1);
    send(0, 1, 0, 8'h33, 2, 0, 0, 1);
    send(0, 1, 0, 8'h44, 3, 1, 0, 1);
    send(0, 1, 1, 8'h55, 0, 0, 0, 1);
    send(0, 1, 0, 8'h66, 1, 0, 0, 1);
    send(0, 1, 0, 8'h77, 2, 0, 0, 1);
    send(0, 1, 0, 8'h88, 3, 1, 0, 1);
    // Long frame: fifth word without marker.
    send(0, 1, 0, 8'h99, -1, 0, 1, 0);
    send(0, 1, 1, 8'h07, 0, 0, 0, 1);
    send(0, 1, 0, 8'h08, 1, 0, 0, 1);
    send(0, 1, 0, 8'h09, 2, 0, 0, 1);
    send(0, 1, 0, 8'h0A, 3, 1, 0, 1);
    // Short frame: marker arrives at channel 2.
    send(0, 1, 1, 8'h10, 0, 0, 0, 1);
    send(0, 1, 0, 8'h20, 1, 0, 0, 1);
    send(0, 1, 1, 8'h30, 0, 0, 1, 1);
    send(0, 1, 0, 8'h40, 1, 0, 0, 1);
    send(0, 0, 0, 8'h00, -1, 0, 0, 0);
    drain();

    // Three channels with idle gaps across two frames.
    send(1, 1, 1, 8'hA0, 0, 0, 0, 1);
    send(1, 0, 1, 8'hFF, -1, 0, 0, 0);
    send(1, 1, 0, 8'hA1, 1, 0, 0, 1);
    send(1, 0, 0, 8'hFE, -1, 0, 0, 0);
    send(1, 0, 1, 8'hFD, -1, 0, 0, 0);
    send(1, 1, 0, 8'hA2, 2, 1, 0, 1);
    send(1, 0, 0, 8'h00, -1, 0, 0, 0);
    send(1, 1, 1, 8'hB0, 0, 0, 0, 1);
    send(1, 1, 0, 8'hB1, 1, 0, 0, 1);
    send(1, 0, 0, 8'h00, -1, 0, 0, 0);
    send(1, 1, 0, 8'hB2, 2, 1, 0, 1);
    send(1, 0, 0, 8'h00, -1, 0, 0, 0);
    drain();
    @(negedge clk);
    chk("n3_frame_count", 32'(fd3), 32'd2);
    chk("n3_locked_end", 32'(b3.locked), 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
